// File: rtl/gesture_pio_in.sv
`timescale 1ns/1ps
// Avalon-MM input PIO for the gesture controller: synchronised inputs, per-bit
// edge capture with write-1-to-clear, interrupt mask and level irq.
module gesture_pio_in #(
  parameter int unsigned       WIDTH                = 8,
  parameter int unsigned       SYNC_STAGES          = 2,
  parameter int unsigned       EDGE_TYPE            = 0,
  parameter logic [WIDTH-1:0]  CAPTURE_ON_RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] data_prev;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] capture_clr;
  logic [31:0]      read_mux;
  logic             wr_en;
  logic             unused_writedata;

  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign data_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_prev <= '0;
    else       data_prev <= data_sync;
  end

  always_comb begin
    edge_event = '0;
    if (EDGE_TYPE == 0)      edge_event = data_sync & ~data_prev;
    else if (EDGE_TYPE == 1) edge_event = ~data_sync & data_prev;
    else                     edge_event = (data_sync & ~data_prev) | (~data_sync & data_prev);
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    capture_clr = '0;
    if (wr_en && address == 2'd3) capture_clr = writedata[WIDTH-1:0];
  end

  // Set is OR'd after the clear so a same-cycle edge is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) edge_capture <= CAPTURE_ON_RESET_VAL;
    else       edge_capture <= (edge_capture & ~capture_clr) | edge_event;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           irq_mask <= '0;
    else if (wr_en && address == 2'd2)   irq_mask <= writedata[WIDTH-1:0];
  end

  always_comb begin
    read_mux = '0;
    case (address)
      2'd0:    read_mux[WIDTH-1:0] = data_sync;
      2'd2:    read_mux[WIDTH-1:0] = irq_mask;
      2'd3:    read_mux[WIDTH-1:0] = edge_capture;
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) readdata <= '0;
    else       readdata <= read_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_gesture_pio_in.sv
`timescale 1ns/1ps
// Bench for gesture_pio_in: four instances (rise/fall/any at WIDTH=8, rise at WIDTH=5)
// share one bus; directed table, hand sequences, then random traffic against a history model.
module tb_gesture_pio_in;

  localparam int unsigned S = 2;
  localparam int unsigned W_OF [4] = '{8, 8, 8, 5};
  localparam int unsigned E_OF [4] = '{0, 1, 2, 0};

  logic             clk;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [7:0]       in_port;
  logic [3:0][31:0] rd;
  logic [3:0]       irq_v;

  int total = 0;
  int bad   = 0;

  gesture_pio_in #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq_v[0]));
  gesture_pio_in #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq_v[1]));
  gesture_pio_in #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq_v[2]));
  gesture_pio_in #(.WIDTH(5), .SYNC_STAGES(S), .EDGE_TYPE(0)) u_w5 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port[4:0]), .readdata(rd[3]), .irq(irq_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: keeps a history of sampled inputs; the value seen by the edge
  // logic at a given edge is the input sampled S edges earlier.
  logic [31:0] hist [S+1];
  logic [31:0] m_cap  [4];
  logic [31:0] m_mask [4];
  logic [31:0] m_rd   [4];

  always @(posedge clk or posedge reset) begin : ref_model
    logic [31:0] s, p, wm, ev, clr, rdv;
    if (reset) begin
      for (int i = 0; i <= S; i++) hist[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        m_cap[i]  <= '0;
        m_mask[i] <= '0;
        m_rd[i]   <= '0;
      end
    end else begin
      for (int i = S; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= {24'h0, in_port};
      for (int i = 0; i < 4; i++) begin
        wm  = (32'd1 << W_OF[i]) - 32'd1;
        s   = hist[S-1] & wm;
        p   = hist[S] & wm;
        ev  = (E_OF[i] == 0) ? (s & ~p) : (E_OF[i] == 1) ? (~s & p) : (s ^ p);
        rdv = (address == 2'd0) ? s : (address == 2'd2) ? m_mask[i] :
              (address == 2'd3) ? m_cap[i] : 32'h0;
        m_rd[i] <= rdv;
        clr = (chipselect && !write_n && address == 2'd3) ? (writedata & wm) : 32'h0;
        if (chipselect && !write_n && address == 2'd2) m_mask[i] <= writedata & wm;
        m_cap[i] <= (m_cap[i] & ~clr) | ev;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] din, input logic [1:0] a, input logic cs,
                       input logic wn, input logic [31:0] wd);
    in_port = din; address = a; chipselect = cs; write_n = wn; writedata = wd;
  endtask

  typedef struct {
    logic [7:0]  din;
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] ea, eb, ec;
    logic        eirq;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{8'h00, 2'd0, 1'b0, 1'b1, 32'h0,  32'h00, 32'h00, 32'h00, 1'b0},
      '{8'hA5, 2'd0, 1'b0, 1'b1, 32'h0,  32'h00, 32'h00, 32'h00, 1'b0},
      '{8'hA5, 2'd0, 1'b0, 1'b1, 32'h0,  32'h00, 32'h00, 32'h00, 1'b0},
      '{8'hA5, 2'd0, 1'b0, 1'b1, 32'h0,  32'hA5, 32'hA5, 32'hA5, 1'b0},
      '{8'h0F, 2'd3, 1'b0, 1'b1, 32'h0,  32'hA5, 32'h00, 32'hA5, 1'b0},
      '{8'h0F, 2'd3, 1'b0, 1'b1, 32'h0,  32'hA5, 32'h00, 32'hA5, 1'b0},
      '{8'h0F, 2'd3, 1'b0, 1'b1, 32'h0,  32'hA5, 32'h00, 32'hA5, 1'b0},
      '{8'h0F, 2'd3, 1'b0, 1'b1, 32'h0,  32'hAF, 32'hA0, 32'hAF, 1'b0},
      '{8'h0F, 2'd3, 1'b1, 1'b0, 32'hFF, 32'hAF, 32'hA0, 32'hAF, 1'b0},
      '{8'h00, 2'd3, 1'b0, 1'b1, 32'h0,  32'h00, 32'h00, 32'h00, 1'b0},
      '{8'h00, 2'd3, 1'b0, 1'b1, 32'h0,  32'h00, 32'h00, 32'h00, 1'b0},
      '{8'h00, 2'd3, 1'b0, 1'b1, 32'h0,  32'h00, 32'h00, 32'h00, 1'b0},
      '{8'h00, 2'd3, 1'b0, 1'b1, 32'h0,  32'h00, 32'h0F, 32'h0F, 1'b0},
      '{8'h00, 2'd0, 1'b0, 1'b1, 32'h0,  32'h00, 32'h00, 32'h00, 1'b0},
      '{8'h00, 2'd1, 1'b0, 1'b1, 32'h0,  32'h00, 32'h00, 32'h00, 1'b0}
    };

    reset = 1'b1;
    drive(8'h00, 2'd0, 1'b0, 1'b1, 32'h0);
    repeat (3) cyc;
    check("reset_readdata", rd[0], 32'h0);
    check("reset_irq", {31'h0, irq_v[0]}, 32'h0);
    reset = 1'b0;
    repeat (3) cyc;

    foreach (tbl[r]) begin
      drive(tbl[r].din, tbl[r].addr, tbl[r].cs, tbl[r].wn, tbl[r].wd);
      cyc;
      check($sformatf("tbl%0d_rise", r), rd[0], tbl[r].ea);
      check($sformatf("tbl%0d_fall", r), rd[1], tbl[r].eb);
      check($sformatf("tbl%0d_any", r),  rd[2], tbl[r].ec);
      check($sformatf("tbl%0d_irq", r),  {31'h0, irq_v[0]}, {31'h0, tbl[r].eirq});
    end

    // IRQ masking
    drive(8'h00, 2'd3, 1'b1, 1'b0, 32'hFF); cyc;
    drive(8'h00, 2'd2, 1'b1, 1'b0, 32'h01); cyc;
    drive(8'h08, 2'd3, 1'b0, 1'b1, 32'h0);  repeat (4) cyc;
    check("mask_off_irq", {31'h0, irq_v[0]}, 32'h0);
    check("mask_off_cap", rd[0], 32'h08);
    drive(8'h08, 2'd2, 1'b1, 1'b0, 32'h08); cyc;
    check("mask_on_irq", {31'h0, irq_v[0]}, 32'h1);
    drive(8'h08, 2'd3, 1'b1, 1'b0, 32'h08); cyc;
    check("w1c_irq", {31'h0, irq_v[0]}, 32'h0);

    // Clear/set collision on bit 2
    drive(8'h08, 2'd2, 1'b1, 1'b0, 32'h04); cyc;
    drive(8'h0C, 2'd3, 1'b0, 1'b1, 32'h0);  repeat (2) cyc;
    drive(8'h0C, 2'd3, 1'b1, 1'b0, 32'h04); cyc;
    check("collide_irq", {31'h0, irq_v[0]}, 32'h1);
    drive(8'h0C, 2'd3, 1'b0, 1'b1, 32'h0);  cyc;
    check("collide_cap", rd[0], 32'h04);
    check("collide_irq2", {31'h0, irq_v[0]}, 32'h1);

    // Width / unused bits
    drive(8'h0C, 2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF); cyc;
    drive(8'h0C, 2'd2, 1'b0, 1'b1, 32'h0); cyc;
    check("w5_mask", rd[3], 32'h1F);
    check("w8_mask", rd[0], 32'hFF);
    drive(8'h0C, 2'd1, 1'b0, 1'b1, 32'h0); cyc;
    check("w5_reserved", rd[3], 32'h0);
    drive(8'h0C, 2'd0, 1'b1, 1'b0, 32'h0); cyc;
    drive(8'h0C, 2'd2, 1'b0, 1'b1, 32'h0); cyc;
    check("w5_data_write_ignored", rd[3], 32'h1F);

    // Async reset mid-cycle with captures and mask all set
    drive(8'h00, 2'd3, 1'b0, 1'b1, 32'h0); repeat (3) cyc;
    drive(8'hFF, 2'd3, 1'b0, 1'b1, 32'h0); repeat (4) cyc;
    check("pre_reset_cap", rd[0], 32'hFF);
    check("pre_reset_irq", {31'h0, irq_v[0]}, 32'h1);
    #2;
    in_port = 8'h00;
    reset = 1'b1;
    #1;
    check("async_reset_readdata", rd[0], 32'h0);
    check("async_reset_irq", {31'h0, irq_v[0]}, 32'h0);
    repeat (2) cyc;
    reset = 1'b0;
    drive(8'h00, 2'd2, 1'b0, 1'b1, 32'h0); cyc;
    check("post_reset_mask", rd[0], 32'h0);
    drive(8'h00, 2'd3, 1'b0, 1'b1, 32'h0); cyc;
    check("post_reset_cap", rd[0], 32'h0);

    // Random traffic against the history model
    for (int n = 0; n < 500; n++) begin
      logic [7:0] din;
      logic       w;
      din = ($urandom_range(0, 2) == 0) ? 8'($urandom) : in_port;
      w   = ($urandom_range(0, 3) == 0);
      drive(din, 2'($urandom), $urandom_range(0, 1) == 1 || w, ~w, $urandom);
      cyc;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rand%0d_rd%0d", n, i), rd[i], m_rd[i]);
        check($sformatf("rand%0d_irq%0d", n, i), {31'h0, irq_v[i]},
              {31'h0, |(m_cap[i] & m_mask[i])});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
